dac_pattern_player: RTL

Host-to-DAC stimulus path: the host streams DAC codes over the Opal Kelly pipe-in (ti_clk domain) into an on-chip pattern memory. The block then plays the pattern out on the DAC clock, as a single shot or as a continuous loop. It complements the ADC capture path by driving the converter input side. Control comes from a wire-in and status goes to a wire-out, both in ti_clk.

---
 rtl/dac_player_pkg.sv | 16 +
 rtl/dac_pattern_ram.sv | 29 ++
 rtl/dac_pattern_player.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/dac_player_pkg.sv
// Shared constants for the DAC pattern player: FSM state codes, midscale idle code
// and the memory depth helper.
package dac_player_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRIME = 2'd1;
    localparam logic [1:0] ST_PLAY  = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    localparam logic [9:0] DEFAULT_IDLE_CODE = 10'h200;

    function automatic int depth(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/dac_pattern_ram.sv
// Simple dual-port, dual-clock pattern RAM: write on the host clock, registered
// read on the DAC clock (1-cycle latency). Contents are never reset.
module dac_pattern_ram
    import dac_player_pkg::*;
#(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 10
) (
    input  logic              wr_clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_clk,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:depth(ADDR_W)-1];

    always_ff @(posedge wr_clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge rd_clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/dac_pattern_player.sv
// Host-loaded DAC pattern player: pipe-in writes fill the pattern RAM in ti_clk,
// a dac_clk FSM plays it out single-shot or looped; status returns to ti_clk.
module dac_pattern_player
    import dac_player_pkg::*;
#(
    parameter int                   PRECISION   = 10,
    parameter int                   ADDR_WIDTH  = 10,
    parameter int                   SYNC_STAGES = 2,
    parameter logic [PRECISION-1:0] IDLE_CODE   = DEFAULT_IDLE_CODE
) (
    input  logic                  rst,
    input  logic                  ti_clk,
    input  logic                  dac_clk,
    input  logic                  pipe_write,
    input  logic [15:0]           pipe_data,
    input  logic                  load_start,
    input  logic                  play_en,
    input  logic                  loop_en,
    output logic [ADDR_WIDTH:0]   words_loaded,
    output logic                  load_error,
    output logic                  playing,
    output logic                  done,
    output logic [PRECISION-1:0]  dac_code,
    output logic                  dac_valid
);

    localparam int                  DEPTH = depth(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] FULL  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE   = (ADDR_WIDTH+1)'(1);

    logic unused_pipe_bits;
    assign unused_pipe_bits = ^pipe_data[15:PRECISION];

    // ---------------- write side (ti_clk) ----------------
    logic [ADDR_WIDTH:0] wr_ptr;
    logic                wr_en;

    assign wr_en        = pipe_write && !load_start && !play_en && (wr_ptr != FULL);
    assign words_loaded = wr_ptr;

    always_ff @(posedge ti_clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            load_error <= 1'b0;
        end else if (load_start) begin
            wr_ptr     <= '0;
            load_error <= 1'b0;
        end else if (pipe_write) begin
            if (wr_en) wr_ptr     <= wr_ptr + ONE;
            else       load_error <= 1'b1;
        end
    end

    // ---------------- pattern memory ----------------
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [PRECISION-1:0]  rd_data;

    dac_pattern_ram #(
        .DATA_W (PRECISION),
        .ADDR_W (ADDR_WIDTH)
    ) u_ram (
        .wr_clk  (ti_clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
        .wr_data (pipe_data[PRECISION-1:0]),
        .rd_clk  (dac_clk),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    // ---------------- control crossing into dac_clk ----------------
    logic [SYNC_STAGES-1:0] play_sync, loop_sync;
    logic                   play_prev, play_s, loop_s, play_rise;

    assign play_s    = play_sync[SYNC_STAGES-1];
    assign loop_s    = loop_sync[SYNC_STAGES-1];
    assign play_rise = play_s && !play_prev;

    // play sync resets to 1 so a play_en held high through reset is not
    // mistaken for a fresh rising edge once reset releases.
    always_ff @(posedge dac_clk or posedge rst) begin
        if (rst) begin
            play_sync <= '1;
            play_prev <= 1'b1;
            loop_sync <= '0;
        end else begin
            play_sync <= {play_sync[SYNC_STAGES-2:0], play_en};
            play_prev <= play_s;
            loop_sync <= {loop_sync[SYNC_STAGES-2:0], loop_en};
        end
    end

    // ---------------- player FSM (dac_clk) ----------------
    logic [1:0]          state, state_nxt;
    logic [ADDR_WIDTH:0] last_idx;
    logic                issue_done, rd_last;
    logic [1:0]          vld_pipe;   // [0]: RAM output valid, [1]: dac_code valid
    logic                act_q, hold_q;

    assign rd_last   = ({1'b0, rd_ptr} == last_idx);
    assign dac_valid = vld_pipe[1];

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        case (state)
            ST_IDLE:  if (play_rise && words_loaded != '0) state_nxt = ST_PRIME;
            ST_PRIME: begin
                rd_en     = 1'b1;
                state_nxt = ST_PLAY;
            end
            ST_PLAY: begin
                rd_en = !issue_done;
                if (issue_done && !vld_pipe[0]) state_nxt = ST_HOLD;
            end
            ST_HOLD:  state_nxt = ST_HOLD;
            default:  state_nxt = ST_IDLE;
        endcase
        if (!play_s) begin
            state_nxt = ST_IDLE;
            rd_en     = 1'b0;
        end
    end

    always_ff @(posedge dac_clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            rd_ptr     <= '0;
            last_idx   <= '0;
            issue_done <= 1'b0;
            vld_pipe   <= '0;
            dac_code   <= IDLE_CODE;
            act_q      <= 1'b0;
            hold_q     <= 1'b0;
        end else begin
            state  <= state_nxt;
            act_q  <= (state_nxt == ST_PRIME) || (state_nxt == ST_PLAY);
            hold_q <= (state_nxt == ST_HOLD);

            // words_loaded is frozen by the write lockout while play_en is high
            if (state == ST_IDLE && state_nxt == ST_PRIME) begin
                last_idx   <= words_loaded - ONE;
                rd_ptr     <= '0;
                issue_done <= 1'b0;
            end else if (rd_en) begin
                if (!rd_last)    rd_ptr     <= rd_ptr + 1'b1;
                else if (loop_s) rd_ptr     <= '0;
                else             issue_done <= 1'b1;
            end

            if (!play_s || state == ST_IDLE) begin
                vld_pipe <= '0;
                dac_code <= IDLE_CODE;
            end else begin
                vld_pipe <= {vld_pipe[0], rd_en};
                if (vld_pipe[0]) dac_code <= rd_data;
            end
        end
    end

    // ---------------- status back to ti_clk ----------------
    logic [SYNC_STAGES-1:0] playing_sync, done_sync;

    always_ff @(posedge ti_clk or posedge rst) begin
        if (rst) begin
            playing_sync <= '0;
            done_sync    <= '0;
        end else begin
            playing_sync <= {playing_sync[SYNC_STAGES-2:0], act_q};
            done_sync    <= {done_sync[SYNC_STAGES-2:0], hold_q};
        end
    end

    assign playing = playing_sync[SYNC_STAGES-1];
    assign done    = done_sync[SYNC_STAGES-1];

endmodule
